jk_bank_ctrl: RTL and testbench
===============================

# jk_bank_ctrl

Command-driven sequencer for a WIDTH-bit register bank of JK flip-flops. Each bit obeys q+ = (j & ~q) | (~k & q). The block accepts one command at a time over a valid/ready handshake and drives per-bit j/k for one or more cycles to clear, set, toggle, load, count or shift the bank. It sits between a host/test controller and the JK storage, and exposes q/qb and the applied j/k for observation.

## Interface
- WIDTH, 4, number of JK bits in the bank (2..16)
- LENW, 4, width of the cycle-count field

- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  high only in IDLE; a command is accepted on the edge where cmd_valid & cmd_ready
- cmd_op  input  3  opcode (see Operation)
- cmd_data  input  WIDTH  mask / load value / serial-in (bit 0)
- cmd_len  input  LENW  repeat count minus one, for COUNT_UP, COUNT_DN and SHIFT
- j  output  WIDTH  J inputs currently applied to the bank
- k  output  WIDTH  K inputs currently applied to the bank
- q  output  WIDTH  bank state
- qb  output  WIDTH  always ~q
- busy  output  1  high in EXEC and DONE
- done  output  1  one-cycle pulse in DONE

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE → EXEC on accept. Latch op, data and len. The remaining-cycles counter is loaded with len for multi-cycle ops and with 0 otherwise.
- EXEC → DONE when the counter is 0. Otherwise decrement and stay in EXEC.
- DONE → IDLE unconditionally.
- j = k = 0 (hold) in IDLE and DONE. In EXEC, j/k are combinational from the latched op and the current q:
  - 0 NOP: j=0, k=0. One EXEC cycle.
  - 1 CLEAR: j=0, k=all ones.
  - 2 SET: j=all ones, k=0.
  - 3 TOGGLE: j=k=data (only the masked bits toggle).
  - 4 LOAD: j=data, k=~data.
  - 5 COUNT_UP: j[i]=k[i]=&q[i-1:0]; j[0]=k[0]=1. Runs len+1 cycles.
  - 6 COUNT_DN: j[i]=k[i]=&~q[i-1:0]; j[0]=k[0]=1. Runs len+1 cycles.
  - 7 SHIFT (left): j[i]=q[i-1], k[i]=~q[i-1]; j[0]=data[0], k[0]=~data[0]. Runs len+1 cycles.
- Ops 0–4 take exactly one EXEC cycle; cmd_len is ignored for them.
- Counting wraps modulo 2^WIDTH with no flag (all ones + 1 = 0; 0 − 1 = all ones).
- For SHIFT, the MSB is discarded and data[0] is shifted in every cycle.
- The data latch holds for the whole command; cmd_* inputs may change after accept without effect.
- cmd_valid outside IDLE is ignored. No queueing, no error.
- The q register updates only via the JK equation; there is no other write path.

## Timing
- Reset (rst sampled high at an edge), effective at that edge:
  - q=0, qb=all ones, j=k=0.
  - State IDLE: cmd_ready=1, busy=0, done=0.
  - Counter and latches cleared.
- rst has priority over everything, including mid-EXEC. An in-flight command is aborted with no done pulse.
- Command accepted at edge E0:
  - EXEC occupies cycles E0..E0+L, where L = len for multi-cycle ops and 0 otherwise.
  - q reflects the final update after edge E0+L+1.
  - done=1 and busy=1 during cycle E0+L+1 (the DONE cycle).
  - cmd_ready returns high after edge E0+L+2.
- Minimum command-to-command spacing: L+3 cycles. A single-cycle op occupies 3 cycles from accept to the next acceptance.
- cmd_len = 2^LENW−1 gives 2^LENW EXEC cycles. There is no overflow on the counter load.
- cmd_valid held high continuously: a new command is accepted on the first IDLE edge after each DONE.

## Test plan
- Reset then idle → q=0x0, qb=0xF, cmd_ready=1, busy=0, j=k=0; holding cmd_valid=0 for 10 cycles leaves q unchanged.
- LOAD data=0xA accepted at E0 → j=0xA and k=0x5 during cycle E0; q=0xA and qb=0x5 after E0+1; done high during cycle E0+1 only; cmd_ready=1 after E0+2.
- From q=0xA: TOGGLE data=0x5 → q=0xF; then CLEAR → q=0x0; then SET → q=0xF; NOP → q stays 0xF and done still pulses.
- LOAD 0xE, then COUNT_UP len=4 → q sequence 0xF, 0x0, 0x1, 0x2, 0x3 (wrap); done after the 5th update. COUNT_DN len=0 from 0x0 → 0xF.
- LOAD 0x3, then SHIFT data[0]=1, len=1 → q 0x7 then 0xF; cmd_valid with op=CLEAR pulsed during busy → ignored, q remains 0xF.
- COUNT_UP len=15 from 0x0, rst asserted at the 6th EXEC cycle → q=0x0, state IDLE, no done pulse; next LOAD 0x9 completes normally.

Source files
------------

// File: rtl/jk_bank_ctrl.sv
// Command sequencer for a bank of JK flip-flops: clear/set/toggle/load in one
// cycle, or count up/down and shift left for cmd_len+1 cycles.
module jk_bank_ctrl #(
    parameter int WIDTH = 4,
    parameter int LENW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LENW-1:0]  cmd_len,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_TOGGLE = 3'd3;
    localparam logic [2:0] OP_LOAD   = 3'd4;
    localparam logic [2:0] OP_CNT_UP = 3'd5;
    localparam logic [2:0] OP_CNT_DN = 3'd6;
    localparam logic [2:0] OP_SHIFT  = 3'd7;

    state_t            state_r;
    logic [2:0]        op_r;
    logic [WIDTH-1:0]  data_r;
    logic [LENW-1:0]   cnt_r;
    logic              ready_r;
    logic              busy_r;
    logic              done_r;
    logic [WIDTH-1:0]  q_r;
    logic [WIDTH-1:0]  j_s;
    logic [WIDTH-1:0]  k_s;
    logic              is_multi_s;

    // Bit i toggles when every lower bit of v is one; bit 0 always toggles.
    function automatic logic [WIDTH-1:0] carry_chain(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] c;
        c    = '0;
        c[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            c[i] = c[i-1] & v[i-1];
        end
        return c;
    endfunction

    // Multi-cycle ops load the repeat counter from cmd_len.
    always_comb begin
        is_multi_s = 1'b0;
        if ((cmd_op == OP_CNT_UP) || (cmd_op == OP_CNT_DN) || (cmd_op == OP_SHIFT)) begin
            is_multi_s = 1'b1;
        end else begin
            is_multi_s = 1'b0;
        end
    end

    // J/K drive: hold outside EXEC, otherwise decoded from latched op and q.
    always_comb begin
        j_s = '0;
        k_s = '0;
        if (state_r == ST_EXEC) begin
            case (op_r)
                OP_NOP:    begin j_s = '0;     k_s = '0;     end
                OP_CLEAR:  begin j_s = '0;     k_s = '1;     end
                OP_SET:    begin j_s = '1;     k_s = '0;     end
                OP_TOGGLE: begin j_s = data_r; k_s = data_r; end
                OP_LOAD:   begin j_s = data_r; k_s = ~data_r; end
                OP_CNT_UP: begin j_s = carry_chain(q_r);  k_s = carry_chain(q_r);  end
                OP_CNT_DN: begin j_s = carry_chain(~q_r); k_s = carry_chain(~q_r); end
                OP_SHIFT:  begin
                    j_s = {q_r[WIDTH-2:0], data_r[0]};
                    k_s = {~q_r[WIDTH-2:0], ~data_r[0]};
                end
                default:   begin j_s = '0;     k_s = '0;     end
            endcase
        end else begin
            j_s = '0;
            k_s = '0;
        end
    end

    // Control FSM with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            op_r    <= OP_NOP;
            data_r  <= '0;
            cnt_r   <= '0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state_r <= ST_EXEC;
                        op_r    <= cmd_op;
                        data_r  <= cmd_data;
                        cnt_r   <= is_multi_s ? cmd_len : {LENW{1'b0}};
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    if (cnt_r == {LENW{1'b0}}) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r - {{(LENW-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Bank storage: the JK equation is the only write path.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= '0;
        end else begin
            q_r <= (j_s & ~q_r) | (~k_s & q_r);
        end
    end

    assign j         = j_s;
    assign k         = k_s;
    assign q         = q_r;
    assign qb        = ~q_r;
    assign cmd_ready = ready_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed bench for jk_bank_ctrl: one task per scenario, inline checks.
module tb_jk_bank_ctrl;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] cmd_len;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] q;
    logic [3:0] qb;
    logic       busy;
    logic       done;

    int pass_cnt;
    int total_cnt;

    jk_bank_ctrl #(.WIDTH(4), .LENW(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len),
        .j(j), .k(k), .q(q), .qb(qb), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a command from IDLE; lat = cycles from accept to the DONE cycle.
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] data,
                           input logic [3:0] len, output int lat);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_len = len;
        tick();
        cmd_valid = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        total_cnt++; if (q !== 4'h0) $display("FAIL reset_q got %h exp 0", q); else pass_cnt++;
        total_cnt++; if (qb !== 4'hF) $display("FAIL reset_qb got %h exp f", qb); else pass_cnt++;
        total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", cmd_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done got %b%b exp 00", busy, done); else pass_cnt++;
        total_cnt++; if (j !== 4'h0 || k !== 4'h0) $display("FAIL reset_jk got %h/%h exp 0/0", j, k); else pass_cnt++;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        total_cnt++; if (q !== 4'h0 || cmd_ready !== 1'b1) $display("FAIL idle_hold got q=%h rdy=%b exp 0/1", q, cmd_ready); else pass_cnt++;
    endtask

    task automatic test_load();
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_data = 4'hA; cmd_len = 4'hF;
        tick();
        cmd_valid = 1'b0; cmd_data = 4'h0;
        total_cnt++; if (j !== 4'hA || k !== 4'h5) $display("FAIL load_jk got %h/%h exp a/5", j, k); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1 || done !== 1'b0 || cmd_ready !== 1'b0) $display("FAIL load_exec_flags got b=%b d=%b r=%b exp 1/0/0", busy, done, cmd_ready); else pass_cnt++;
        tick();
        total_cnt++; if (q !== 4'hA || qb !== 4'h5) $display("FAIL load_q got %h/%h exp a/5", q, qb); else pass_cnt++;
        total_cnt++; if (done !== 1'b1 || busy !== 1'b1) $display("FAIL load_done got d=%b b=%b exp 1/1", done, busy); else pass_cnt++;
        total_cnt++; if (j !== 4'h0 || k !== 4'h0) $display("FAIL load_done_jk got %h/%h exp 0/0", j, k); else pass_cnt++;
        tick();
        total_cnt++; if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL load_idle got d=%b r=%b b=%b exp 0/1/0", done, cmd_ready, busy); else pass_cnt++;
        total_cnt++; if (q !== 4'hA) $display("FAIL load_hold got %h exp a", q); else pass_cnt++;
    endtask

    task automatic test_basic_ops();
        int lat;
        run_cmd(3'd3, 4'h5, 4'h7, lat);
        total_cnt++; if (q !== 4'hF || lat !== 1) $display("FAIL toggle got q=%h lat=%0d exp f/1", q, lat); else pass_cnt++;
        run_cmd(3'd1, 4'h0, 4'h7, lat);
        total_cnt++; if (q !== 4'h0 || lat !== 1) $display("FAIL clear got q=%h lat=%0d exp 0/1", q, lat); else pass_cnt++;
        run_cmd(3'd2, 4'h0, 4'h7, lat);
        total_cnt++; if (q !== 4'hF || lat !== 1) $display("FAIL set got q=%h lat=%0d exp f/1", q, lat); else pass_cnt++;
        run_cmd(3'd0, 4'h3, 4'h7, lat);
        total_cnt++; if (q !== 4'hF || lat !== 1) $display("FAIL nop got q=%h lat=%0d exp f/1", q, lat); else pass_cnt++;
    endtask

    task automatic test_count();
        int lat;
        logic [3:0] exp_seq [5];
        exp_seq = '{4'hF, 4'h0, 4'h1, 4'h2, 4'h3};
        run_cmd(3'd4, 4'hE, 4'h0, lat);
        total_cnt++; if (q !== 4'hE) $display("FAIL cnt_preload got %h exp e", q); else pass_cnt++;
        cmd_valid = 1'b1; cmd_op = 3'd5; cmd_data = 4'h0; cmd_len = 4'd4;
        tick();
        cmd_valid = 1'b0; cmd_len = 4'd0;
        for (int n = 0; n < 5; n++) begin
            tick();
            total_cnt++;
            if (q !== exp_seq[n] || done !== (n == 4))
                $display("FAIL count_up_step%0d got q=%h d=%b exp %h/%b", n, q, done, exp_seq[n], (n == 4));
            else pass_cnt++;
        end
        tick();
        run_cmd(3'd1, 4'h0, 4'h0, lat);
        run_cmd(3'd6, 4'h0, 4'h0, lat);
        total_cnt++; if (q !== 4'hF || lat !== 1) $display("FAIL count_dn_wrap got q=%h lat=%0d exp f/1", q, lat); else pass_cnt++;
    endtask

    task automatic test_shift();
        int lat;
        run_cmd(3'd4, 4'h3, 4'h0, lat);
        cmd_valid = 1'b1; cmd_op = 3'd7; cmd_data = 4'h1; cmd_len = 4'd1;
        tick();
        total_cnt++; if (j !== 4'h7 || k !== 4'h8) $display("FAIL shift_jk got %h/%h exp 7/8", j, k); else pass_cnt++;
        cmd_op = 3'd1; cmd_data = 4'h0;
        tick();
        total_cnt++; if (q !== 4'h7 || cmd_ready !== 1'b0) $display("FAIL shift_step1 got q=%h r=%b exp 7/0", q, cmd_ready); else pass_cnt++;
        cmd_valid = 1'b0;
        tick();
        total_cnt++; if (q !== 4'hF || done !== 1'b1) $display("FAIL shift_step2 got q=%h d=%b exp f/1", q, done); else pass_cnt++;
        tick();
        tick();
        total_cnt++; if (q !== 4'hF || cmd_ready !== 1'b1) $display("FAIL shift_ignore got q=%h r=%b exp f/1", q, cmd_ready); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_data = 4'h1; cmd_len = 4'd0;
        tick();
        tick();
        total_cnt++; if (q !== 4'hE || done !== 1'b1) $display("FAIL b2b_first got q=%h d=%b exp e/1", q, done); else pass_cnt++;
        tick();
        total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready got %b exp 1", cmd_ready); else pass_cnt++;
        tick();
        total_cnt++; if (busy !== 1'b1 || cmd_ready !== 1'b0) $display("FAIL b2b_accept got b=%b r=%b exp 1/0", busy, cmd_ready); else pass_cnt++;
        cmd_valid = 1'b0;
        tick();
        total_cnt++; if (q !== 4'hF || done !== 1'b1) $display("FAIL b2b_second got q=%h d=%b exp f/1", q, done); else pass_cnt++;
        tick();
    endtask

    task automatic test_abort();
        int lat;
        int seen_done;
        run_cmd(3'd1, 4'h0, 4'h0, lat);
        cmd_valid = 1'b1; cmd_op = 3'd5; cmd_data = 4'h0; cmd_len = 4'd15;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total_cnt++; if (q !== 4'h5 || busy !== 1'b1) $display("FAIL abort_pre got q=%h b=%b exp 5/1", q, busy); else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++; if (q !== 4'h0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL abort_reset got q=%h r=%b b=%b d=%b exp 0/1/0/0", q, cmd_ready, busy, done);
        else pass_cnt++;
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done === 1'b1) seen_done++;
        end
        total_cnt++; if (seen_done !== 0 || q !== 4'h0) $display("FAIL abort_no_done got %0d pulses q=%h exp 0/0", seen_done, q); else pass_cnt++;
        run_cmd(3'd4, 4'h9, 4'h0, lat);
        total_cnt++; if (q !== 4'h9 || lat !== 1) $display("FAIL abort_next_load got q=%h lat=%0d exp 9/1", q, lat); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 4'h0;
        cmd_len   = 4'h0;
        #1;
        test_reset();
        test_load();
        test_basic_ops();
        test_count();
        test_shift();
        test_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
